// File: rtl/cordic_share_sequencer.sv
// Round-robin front end for one folded CORDIC datapath shared by two requesters.
// Latches the winning operand, steps the pass counter and returns the captured result to its owner.
module cordic_share_sequencer #(
  parameter int NUM_PASSES = 4,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              dp_load,
  output logic [2:0]        dp_count,
  output logic [DATA_W-1:0] dp_operand,
  input  logic [DATA_W-1:0] dp_result,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [2:0] LAST_PASS = 3'(NUM_PASSES - 1);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [2:0]        dp_count_q, dp_count_d;
  logic [DATA_W-1:0] dp_operand_q, dp_operand_d;
  logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d;
  logic [DATA_W-1:0] rsp1_data_q, rsp1_data_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic              dp_load_q, dp_load_d;
  logic              busy_q, busy_d;
  logic              grant0, grant1;

  // Grant and next-state logic; dp_load/busy/rsp_valid are set one edge early so they come out of flops.
  always_comb begin
    grant0       = 1'b0;
    grant1       = 1'b0;
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    dp_count_d   = dp_count_q;
    dp_operand_d = dp_operand_q;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    dp_load_d    = 1'b0;
    busy_d       = busy_q;

    if (state_q == IDLE) begin
      grant0 = req0_valid && (!req1_valid || last_grant_q);
      grant1 = req1_valid && (!req0_valid || !last_grant_q);
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          dp_operand_d = grant0 ? req0_data : req1_data;
          owner_d      = grant1;
          dp_count_d   = 3'd0;
          dp_load_d    = 1'b1;
          busy_d       = 1'b1;
          state_d      = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (dp_count_q == LAST_PASS) begin
          if (owner_q) begin
            rsp1_data_d  = dp_result;
            rsp1_valid_d = 1'b1;
          end else begin
            rsp0_data_d  = dp_result;
            rsp0_valid_d = 1'b1;
          end
          dp_count_d = 3'd0;
          state_d    = RESP;
        end else begin
          dp_count_d = dp_count_q + 3'd1;
        end
      end
      RESP: begin
        last_grant_d = owner_q;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: begin
        dp_count_d = 3'd0;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      dp_count_q   <= 3'd0;
      dp_operand_q <= '0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      dp_load_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      dp_count_q   <= dp_count_d;
      dp_operand_q <= dp_operand_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      dp_load_q    <= dp_load_d;
      busy_q       <= busy_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
  assign dp_load    = dp_load_q;
  assign dp_count   = dp_count_q;
  assign dp_operand = dp_operand_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cordic_share_sequencer.sv
// Bench for cordic_share_sequencer: a 4-pass and a 1-pass instance checked every cycle against a
// timeline model (phase = cycles since accept), plus directed literal expectations.
module tb_cordic_share_sequencer;
  localparam int DW   = 32;
  localparam int NP_A = 4;
  localparam int NP_B = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          v0 [2];
  logic          v1 [2];
  logic [DW-1:0] d0 [2];
  logic [DW-1:0] d1 [2];

  logic          r0_a, r1_a, rv0_a, rv1_a, ld_a, busy_a;
  logic [2:0]    cnt_a;
  logic [DW-1:0] rd0_a, rd1_a, op_a, res_a;
  logic          r0_b, r1_b, rv0_b, rv1_b, ld_b, busy_b;
  logic [2:0]    cnt_b;
  logic [DW-1:0] rd0_b, rd1_b, op_b, res_b;

  cordic_share_sequencer #(.NUM_PASSES(NP_A), .DATA_W(DW)) dut_a (
    .clk(clk), .reset(reset),
    .req0_valid(v0[0]), .req0_data(d0[0]), .req0_ready(r0_a),
    .req1_valid(v1[0]), .req1_data(d1[0]), .req1_ready(r1_a),
    .rsp0_valid(rv0_a), .rsp0_data(rd0_a), .rsp1_valid(rv1_a), .rsp1_data(rd1_a),
    .dp_load(ld_a), .dp_count(cnt_a), .dp_operand(op_a), .dp_result(res_a), .busy(busy_a)
  );

  cordic_share_sequencer #(.NUM_PASSES(NP_B), .DATA_W(DW)) dut_b (
    .clk(clk), .reset(reset),
    .req0_valid(v0[1]), .req0_data(d0[1]), .req0_ready(r0_b),
    .req1_valid(v1[1]), .req1_data(d1[1]), .req1_ready(r1_b),
    .rsp0_valid(rv0_b), .rsp0_data(rd0_b), .rsp1_valid(rv1_b), .rsp1_data(rd1_b),
    .dp_load(ld_b), .dp_count(cnt_b), .dp_operand(op_b), .dp_result(res_b), .busy(busy_b)
  );

  // Model: phase 0 = idle, 1..NP = k-th cycle after accept, NP+1 = response cycle.
  int            m_phase [2];
  logic          m_last  [2];
  logic          m_owner [2];
  logic [DW-1:0] m_op    [2];
  logic [DW-1:0] m_rd0   [2];
  logic [DW-1:0] m_rd1   [2];
  int            cyc = 0;
  int            n_chk = 0;
  int            n_pass = 0;

  function automatic int np_of(input int i);
    return (i == 0) ? NP_A : NP_B;
  endfunction

  // Stand-in for the CORDIC datapath: one known pair, otherwise an operand tag.
  function automatic logic [DW-1:0] dp_fn(input logic [DW-1:0] x);
    if (x == 32'h3F00_0000) return 32'h3F60_A8B0;
    return x ^ 32'h0F0F_0F0F;
  endfunction

  function automatic logic m_grant(input int i, input int n);
    if (m_phase[i] != 0) return 1'b0;
    if (n == 0) return v0[i] && (!v1[i] || m_last[i] == 1'b1);
    return v1[i] && (!v0[i] || m_last[i] == 1'b0);
  endfunction

  // Result only meaningful in the last cycle before the response.
  assign res_a = (m_phase[0] == NP_A) ? dp_fn(m_op[0]) : 32'hDEAD_BEEF;
  assign res_b = (m_phase[1] == NP_B) ? dp_fn(m_op[1]) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_phase[i] <= 0;
        m_last[i]  <= 1'b1;
        m_owner[i] <= 1'b0;
        m_op[i]    <= '0;
        m_rd0[i]   <= '0;
        m_rd1[i]   <= '0;
      end else if (m_phase[i] == 0) begin
        if (m_grant(i, 0)) begin
          m_op[i] <= d0[i]; m_owner[i] <= 1'b0; m_phase[i] <= 1;
        end else if (m_grant(i, 1)) begin
          m_op[i] <= d1[i]; m_owner[i] <= 1'b1; m_phase[i] <= 1;
        end
      end else if (m_phase[i] <= np_of(i)) begin
        if (m_phase[i] == np_of(i)) begin
          if (m_owner[i]) m_rd1[i] <= dp_fn(m_op[i]);
          else            m_rd0[i] <= dp_fn(m_op[i]);
        end
        m_phase[i] <= m_phase[i] + 1;
      end else begin
        m_last[i]  <= m_owner[i];
        m_phase[i] <= 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    else n_pass++;
  endtask

  task automatic cmp(input int i, input logic r0, input logic r1, input logic rv0, input logic rv1,
                     input logic [DW-1:0] rd0, input logic [DW-1:0] rd1, input logic ld,
                     input logic [2:0] cnt, input logic [DW-1:0] op, input logic bsy);
    int ph;
    int np;
    ph = m_phase[i];
    np = np_of(i);
    chk($sformatf("np%0d req0_ready", np), r0, m_grant(i, 0));
    chk($sformatf("np%0d req1_ready", np), r1, m_grant(i, 1));
    chk($sformatf("np%0d rsp0_valid", np), rv0, (ph == np + 1) && !m_owner[i]);
    chk($sformatf("np%0d rsp1_valid", np), rv1, (ph == np + 1) && m_owner[i]);
    chk($sformatf("np%0d rsp0_data", np), rd0, m_rd0[i]);
    chk($sformatf("np%0d rsp1_data", np), rd1, m_rd1[i]);
    chk($sformatf("np%0d dp_load", np), ld, ph == 1);
    chk($sformatf("np%0d dp_count", np), cnt, (ph >= 1 && ph <= np) ? ph - 1 : 0);
    chk($sformatf("np%0d dp_operand", np), op, m_op[i]);
    chk($sformatf("np%0d busy", np), bsy, ph != 0);
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      cmp(0, r0_a, r1_a, rv0_a, rv1_a, rd0_a, rd1_a, ld_a, cnt_a, op_a, busy_a);
      cmp(1, r0_b, r1_b, rv0_b, rv1_b, rd0_b, rd1_b, ld_b, cnt_b, op_b, busy_b);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    int n_rsp;
    int n_acc;
    int found;
    int acc;
    int first;
    int lastn;
    int saw0;
    logic done;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      v0[i] = 1'b0; v1[i] = 1'b0; d0[i] = '0; d1[i] = '0;
    end
    step(); step(); step();
    reset = 1'b0;
    smp();
    chk("rst dp_count", cnt_a, 32'd0);
    chk("rst dp_operand", op_a, 32'd0);
    chk("rst busy", busy_a, 32'd0);
    chk("rst rsp0_data", rd0_a, 32'd0);

    // Single request on the 4-pass instance.
    step(); v0[0] = 1'b1; d0[0] = 32'h3F00_0000;
    smp(); chk("t1 ready0", r0_a, 32'd1);
    step(); v0[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("t1 dp_load", ld_a, (k == 0) ? 32'd1 : 32'd0);
      chk("t1 dp_count", cnt_a, 32'(k));
      chk("t1 busy", busy_a, 32'd1);
      step();
    end
    smp();
    chk("t1 rsp0_valid", rv0_a, 32'd1);
    chk("t1 rsp0_data", rd0_a, 32'h3F60_A8B0);
    chk("t1 rsp1_valid", rv1_a, 32'd0);
    step(); smp();
    chk("t1 rsp0 pulse end", rv0_a, 32'd0);
    chk("t1 busy end", busy_a, 32'd0);

    // Tie straight out of reset: req0 first, req1 six cycles later.
    reset = 1'b1;
    v0[0] = 1'b1; d0[0] = 32'h3F00_0000;
    v1[0] = 1'b1; d1[0] = 32'h3F80_0000;
    step(); step(); reset = 1'b0;
    smp();
    chk("t2 ready0", r0_a, 32'd1);
    chk("t2 ready1", r1_a, 32'd0);
    step(); v0[0] = 1'b0;
    n_rsp = -1; n_acc = -1;
    for (int n = 1; n <= 12 && n_acc < 0; n++) begin
      smp();
      if (rv0_a) n_rsp = n;
      if (r1_a) n_acc = n;
      else step();
    end
    chk("t2 rsp0 latency", 32'(n_rsp), 32'd5);
    chk("t2 req1 accept gap", 32'(n_acc), 32'd6);
    step(); v1[0] = 1'b0;
    n_rsp = -1;
    for (int n = 1; n <= 10 && n_rsp < 0; n++) begin
      smp();
      if (rv1_a) begin
        n_rsp = n;
        chk("t2 rsp1_data", rd1_a, 32'h308F_0F0F);
        chk("t2 rsp0_data kept", rd0_a, 32'h3F60_A8B0);
      end
      step();
    end
    chk("t2 rsp1 latency", 32'(n_rsp), 32'd5);

    // Fairness with both requesters held valid.
    v0[0] = 1'b1; d0[0] = 32'h4000_0000;
    v1[0] = 1'b1; d1[0] = 32'h4040_0000;
    for (int op = 0; op < 4; op++) begin
      found = -1;
      for (int n = 0; n <= 12 && found < 0; n++) begin
        smp();
        if (r0_a) found = 0;
        else if (r1_a) found = 1;
        else step();
      end
      chk("t3 grant order", 32'(found), 32'(op % 2));
      step();
      if (op == 3) begin v0[0] = 1'b0; v1[0] = 1'b0; end
    end
    done = 1'b0;
    for (int n = 0; n <= 12 && !done; n++) begin
      smp();
      if (!busy_a) done = 1'b1;
      else step();
    end
    chk("t3 drained", done, 32'd1);
    chk("t3 rsp0_data", rd0_a, 32'h4F0F_0F0F);
    chk("t3 rsp1_data", rd1_a, 32'h4F4F_0F0F);

    // Waiting requester changes its data; latched operand must not move.
    step();
    v0[0] = 1'b1; d0[0] = 32'h1111_1111;
    v1[0] = 1'b1; d1[0] = 32'h2222_2222;
    smp(); chk("t4 ready0", r0_a, 32'd1);
    step(); v0[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      smp(); chk("t4 operand stable", op_a, 32'h1111_1111);
      step();
      if (k == 1) d1[0] = 32'h3333_3333;
    end
    found = -1;
    for (int n = 0; n <= 6 && found < 0; n++) begin
      smp();
      if (r1_a) found = n;
      else step();
    end
    chk("t4 req1 granted", 32'(found >= 0), 32'd1);
    step(); v1[0] = 1'b0;
    smp(); chk("t4 operand req1", op_a, 32'h3333_3333);
    done = 1'b0;
    for (int n = 0; n <= 12 && !done; n++) begin
      step(); smp();
      if (!busy_a) done = 1'b1;
    end
    chk("t4 drained", done, 32'd1);

    // Reset in the middle of RUN with req1 still holding.
    step();
    v0[0] = 1'b1; d0[0] = 32'h4444_4444;
    v1[0] = 1'b1; d1[0] = 32'h5555_5555;
    smp(); chk("t5 ready0", r0_a, 32'd1);
    step(); v0[0] = 1'b0;
    found = -1;
    for (int n = 0; n <= 6 && found < 0; n++) begin
      smp();
      if (busy_a && cnt_a == 3'd2) found = n;
      else step();
    end
    chk("t5 reached count 2", 32'(found), 32'd2);
    reset = 1'b1;
    step(); reset = 1'b0;
    smp();
    chk("t5 dp_count after reset", cnt_a, 32'd0);
    chk("t5 busy after reset", busy_a, 32'd0);
    chk("t5 rsp0_valid after reset", rv0_a, 32'd0);
    chk("t5 req1 re-accepted", r1_a, 32'd1);
    step(); v1[0] = 1'b0;
    n_rsp = -1; saw0 = 0;
    for (int n = 1; n <= 8; n++) begin
      smp();
      if (rv0_a) saw0++;
      if (rv1_a && n_rsp < 0) begin
        n_rsp = n;
        chk("t5 rsp1_data", rd1_a, 32'h5A5A_5A5A);
      end
      step();
    end
    chk("t5 no rsp0 for discarded op", 32'(saw0), 32'd0);
    chk("t5 rsp1 latency", 32'(n_rsp), 32'd5);

    // One-pass instance: single request, then throughput.
    v0[1] = 1'b1; d0[1] = 32'h3F00_0000;
    smp(); chk("t6 ready0", r0_b, 32'd1);
    step(); v0[1] = 1'b0;
    smp();
    chk("t6 dp_load", ld_b, 32'd1);
    chk("t6 dp_count", cnt_b, 32'd0);
    chk("t6 busy", busy_b, 32'd1);
    step(); smp();
    chk("t6 rsp0_valid", rv0_b, 32'd1);
    chk("t6 rsp0_data", rd0_b, 32'h3F60_A8B0);
    step();
    v0[1] = 1'b1; d0[1] = 32'h6000_0000;
    v1[1] = 1'b1; d1[1] = 32'h7000_0000;
    acc = 0; first = -1; lastn = -1;
    for (int n = 0; n < 9; n++) begin
      smp();
      if (r0_b || r1_b) begin
        acc++;
        if (first < 0) first = n;
        lastn = n;
      end
      step();
    end
    v0[1] = 1'b0; v1[1] = 1'b0;
    chk("t6 accepts in 9 cycles", 32'(acc), 32'd3);
    chk("t6 first accept", 32'(first), 32'd0);
    chk("t6 last accept", 32'(lastn), 32'd6);
    chk("t6 rsp1_data", rd1_b, 32'h7F0F_0F0F);

    step(); step(); step();
    smp();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
